// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding mux selects, load-use stall and
// taken-branch flush sequencing, plus a saturating stall-cycle counter.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_RUN   | normal issue; a taken branch flushes, a load-use stalls one cycle
// S_FLUSH | extra flush cycles after a taken branch; fcnt_q counts them down
module hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [4:0]       id_rs1_addr_i,
    input  logic [4:0]       id_rs2_addr_i,
    input  logic             id_rs1_used_i,
    input  logic             id_rs2_used_i,
    input  logic [4:0]       ex_rs1_addr_i,
    input  logic [4:0]       ex_rs2_addr_i,
    input  logic             ex_reg_wr_i,
    input  logic             ex_mem_rd_i,
    input  logic [4:0]       ex_wb_addr_i,
    input  logic             branch_taken_ex_i,
    output logic             pc_hold_o,
    output logic             ifid_hold_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic [1:0]       fwd_a_sel_o,
    output logic [1:0]       fwd_b_sel_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic             busy_flush_o
);

    typedef enum logic [0:0] {
        S_RUN   = 1'b0,
        S_FLUSH = 1'b1
    } state_e;

    localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);
    localparam logic [1:0] SEL_RF     = 2'b00;
    localparam logic [1:0] SEL_MEMWB  = 2'b01;
    localparam logic [1:0] SEL_EXMEM  = 2'b10;

    state_e           state_q, state_d;
    logic [2:0]       fcnt_q, fcnt_d;
    logic             exmem_reg_wr_q, exmem_mem_rd_q;
    logic [4:0]       exmem_wb_addr_q;
    logic             memwb_reg_wr_q;
    logic [4:0]       memwb_wb_addr_q;
    logic [CNT_W-1:0] stall_cnt_q;

    logic             load_use;
    logic             pc_hold_d, ifid_hold_d, ifid_flush_d, idex_bubble_d;
    logic [1:0]       fwd_a_d, fwd_b_d;

    // Shadow copies of the downstream pipeline registers; they track every cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            exmem_reg_wr_q  <= 1'b0;
            exmem_mem_rd_q  <= 1'b0;
            exmem_wb_addr_q <= 5'd0;
            memwb_reg_wr_q  <= 1'b0;
            memwb_wb_addr_q <= 5'd0;
        end else begin
            exmem_reg_wr_q  <= ex_reg_wr_i;
            exmem_mem_rd_q  <= ex_mem_rd_i;
            exmem_wb_addr_q <= ex_wb_addr_i;
            memwb_reg_wr_q  <= exmem_reg_wr_q;
            memwb_wb_addr_q <= exmem_wb_addr_q;
        end
    end

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       em_wr,
        input logic       em_rd,
        input logic [4:0] em_addr,
        input logic       mw_wr,
        input logic [4:0] mw_addr
    );
        logic [1:0] sel;
        sel = SEL_RF;
        // A load still in EX/MEM has no data yet; it can only forward from MEM/WB.
        if (em_wr && !em_rd && (em_addr != 5'd0) && (em_addr == src)) begin
            sel = SEL_EXMEM;
        end else if (mw_wr && (mw_addr != 5'd0) && (mw_addr == src)) begin
            sel = SEL_MEMWB;
        end
        return sel;
    endfunction

    always_comb begin
        fwd_a_d = fwd_sel(ex_rs1_addr_i, exmem_reg_wr_q, exmem_mem_rd_q, exmem_wb_addr_q,
                          memwb_reg_wr_q, memwb_wb_addr_q);
        fwd_b_d = fwd_sel(ex_rs2_addr_i, exmem_reg_wr_q, exmem_mem_rd_q, exmem_wb_addr_q,
                          memwb_reg_wr_q, memwb_wb_addr_q);
    end

    assign load_use = ex_mem_rd_i & ex_reg_wr_i & (ex_wb_addr_i != 5'd0) &
                      ((id_rs1_used_i & (ex_wb_addr_i == id_rs1_addr_i)) |
                       (id_rs2_used_i & (ex_wb_addr_i == id_rs2_addr_i)));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_RUN;
            fcnt_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        fcnt_d        = fcnt_q;
        pc_hold_d     = 1'b0;
        ifid_hold_d   = 1'b0;
        ifid_flush_d  = 1'b0;
        idex_bubble_d = 1'b0;
        case (state_q)
            S_RUN: begin
                if (branch_taken_ex_i) begin
                    ifid_flush_d  = 1'b1;
                    idex_bubble_d = 1'b1;
                    if (FLUSH_LAST != 3'd0) begin
                        state_d = S_FLUSH;
                        fcnt_d  = FLUSH_LAST;
                    end
                end else if (load_use) begin
                    pc_hold_d     = 1'b1;
                    ifid_hold_d   = 1'b1;
                    idex_bubble_d = 1'b1;
                end
            end
            S_FLUSH: begin
                ifid_flush_d  = 1'b1;
                idex_bubble_d = 1'b1;
                fcnt_d        = fcnt_q - 3'd1;
                // Leave once the count reaches zero, so the branch cycle plus
                // FLUSH_CYCLES-1 cycles here make up the whole flush.
                if (fcnt_q <= 3'd1) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_RUN;
                fcnt_d  = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt_q <= '0;
        end else if (pc_hold_d && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    // Outputs are gated by rstn so reset silences them even with hazards on the inputs.
    assign pc_hold_o     = rstn & pc_hold_d;
    assign ifid_hold_o   = rstn & ifid_hold_d;
    assign ifid_flush_o  = rstn & ifid_flush_d;
    assign idex_bubble_o = rstn & idex_bubble_d;
    assign busy_flush_o  = rstn & (state_q == S_FLUSH);
    assign fwd_a_sel_o   = rstn ? fwd_a_d : SEL_RF;
    assign fwd_b_sel_o   = rstn ? fwd_b_d : SEL_RF;
    assign stall_cnt_o   = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized
// traffic compared against a behavioural model of forwarding, stalls and flushes.
module tb_hazard_ctrl;
    localparam int FC      = 2;
    localparam int CNT_W   = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rstn;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_wb;
    logic id_u1, id_u2, ex_wr, ex_rd, br;
    logic pc_hold, ifid_hold, ifid_flush, idex_bubble, busy_flush;
    logic [1:0] fwd_a, fwd_b;
    logic [CNT_W-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    // Model: history of the last two EX instructions, remaining flush cycles, stall count.
    bit       h1_wr, h1_rd, h2_wr;
    bit [4:0] h1_a, h2_a;
    int       flush_rem;
    int       m_cnt;
    bit       e_pc, e_ifh, e_iff, e_bub, e_busy;
    bit [1:0] e_fa, e_fb;

    always #5 clk = ~clk;

    hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rstn(rstn),
        .id_rs1_addr_i(id_rs1), .id_rs2_addr_i(id_rs2),
        .id_rs1_used_i(id_u1), .id_rs2_used_i(id_u2),
        .ex_rs1_addr_i(ex_rs1), .ex_rs2_addr_i(ex_rs2),
        .ex_reg_wr_i(ex_wr), .ex_mem_rd_i(ex_rd), .ex_wb_addr_i(ex_wb),
        .branch_taken_ex_i(br),
        .pc_hold_o(pc_hold), .ifid_hold_o(ifid_hold), .ifid_flush_o(ifid_flush),
        .idex_bubble_o(idex_bubble), .fwd_a_sel_o(fwd_a), .fwd_b_sel_o(fwd_b),
        .stall_cnt_o(stall_cnt), .busy_flush_o(busy_flush)
    );

    task automatic clear_inputs();
        id_rs1 = 0; id_rs2 = 0; ex_rs1 = 0; ex_rs2 = 0; ex_wb = 0;
        id_u1 = 0; id_u2 = 0; ex_wr = 0; ex_rd = 0; br = 0;
    endtask

    task automatic model_reset();
        h1_wr = 0; h1_rd = 0; h1_a = 0; h2_wr = 0; h2_a = 0;
        flush_rem = 0; m_cnt = 0;
    endtask

    function automatic bit [1:0] ref_fwd(input bit [4:0] src);
        if (h1_wr && !h1_rd && h1_a != 0 && h1_a == src) return 2'b10;
        if (h2_wr && h2_a != 0 && h2_a == src) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_eval();
        bit lu;
        lu = ex_rd && ex_wr && ex_wb != 0 &&
             ((id_u1 && ex_wb == id_rs1) || (id_u2 && ex_wb == id_rs2));
        e_fa = ref_fwd(ex_rs1);
        e_fb = ref_fwd(ex_rs2);
        {e_pc, e_ifh, e_iff, e_bub, e_busy} = '0;
        if (flush_rem > 0) begin
            e_iff = 1; e_bub = 1; e_busy = 1;
        end else if (br) begin
            e_iff = 1; e_bub = 1;
        end else if (lu) begin
            e_pc = 1; e_ifh = 1; e_bub = 1;
        end
    endtask

    task automatic model_advance();
        if (e_pc && m_cnt < CNT_MAX) m_cnt++;
        if (flush_rem > 0) flush_rem--;
        else if (br) flush_rem = FC - 1;
        h2_wr = h1_wr; h2_a = h1_a;
        h1_wr = ex_wr; h1_rd = ex_rd; h1_a = ex_wb;
    endtask

    task automatic tick();
        model_eval();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic test_reset();
        ex_rd = 1; ex_wr = 1; ex_wb = 7; id_rs2 = 7; id_u2 = 1; br = 1;
        ex_rs1 = 7; ex_rs2 = 7;
        @(posedge clk); #1;
        checks++;
        if ({pc_hold, ifid_hold, ifid_flush, idex_bubble, busy_flush} !== 5'b0) begin
            errors++; $display("FAIL rst_ctrl got %b exp 00000",
                {pc_hold, ifid_hold, ifid_flush, idex_bubble, busy_flush});
        end
        checks++;
        if ({fwd_a, fwd_b} !== 4'b0) begin
            errors++; $display("FAIL rst_fwd got %b exp 0000", {fwd_a, fwd_b});
        end
        checks++;
        if (stall_cnt !== '0) begin
            errors++; $display("FAIL rst_cnt got %0d exp 0", stall_cnt);
        end
        clear_inputs();
        rstn = 1;
        model_reset();
        #1;
        checks++;
        if ({pc_hold, ifid_hold, ifid_flush, idex_bubble, busy_flush, fwd_a, fwd_b} !== 9'b0) begin
            errors++; $display("FAIL rst_idle got %b exp 0",
                {pc_hold, ifid_hold, ifid_flush, idex_bubble, busy_flush, fwd_a, fwd_b});
        end
        tick();
    endtask

    task automatic test_forward();
        clear_inputs(); ex_wr = 1; ex_wb = 5; tick();
        clear_inputs(); ex_rs1 = 5; #1;
        checks++;
        if (fwd_a !== 2'b10 || fwd_b !== 2'b00) begin
            errors++; $display("FAIL fwd_exmem got a=%b b=%b exp a=10 b=00", fwd_a, fwd_b);
        end
        tick();
        clear_inputs(); ex_rs2 = 5; #1;
        checks++;
        if (fwd_b !== 2'b01 || fwd_a !== 2'b00) begin
            errors++; $display("FAIL fwd_memwb got a=%b b=%b exp a=00 b=01", fwd_a, fwd_b);
        end
        tick();
        clear_inputs(); ex_wr = 1; ex_wb = 0; tick();
        clear_inputs(); #1;
        checks++;
        if ({fwd_a, fwd_b} !== 4'b0) begin
            errors++; $display("FAIL fwd_x0_exmem got %b exp 0000", {fwd_a, fwd_b});
        end
        tick(); #1;
        checks++;
        if ({fwd_a, fwd_b} !== 4'b0) begin
            errors++; $display("FAIL fwd_x0_memwb got %b exp 0000", {fwd_a, fwd_b});
        end
        clear_inputs(); ex_wr = 1; ex_rd = 1; ex_wb = 9; tick();
        clear_inputs(); ex_rs1 = 9; #1;
        checks++;
        if (fwd_a !== 2'b00) begin
            errors++; $display("FAIL fwd_load_exmem got %b exp 00", fwd_a);
        end
        tick(); #1;
        checks++;
        if (fwd_a !== 2'b01) begin
            errors++; $display("FAIL fwd_load_memwb got %b exp 01", fwd_a);
        end
        clear_inputs(); ex_wr = 1; ex_wb = 4; tick(); tick();
        clear_inputs(); ex_rs2 = 4; #1;
        checks++;
        if (fwd_b !== 2'b10) begin
            errors++; $display("FAIL fwd_priority got %b exp 10", fwd_b);
        end
        tick();
    endtask

    task automatic test_load_use();
        clear_inputs(); ex_rd = 1; ex_wr = 1; ex_wb = 7; id_rs2 = 7; id_u2 = 1; #1;
        checks++;
        if ({pc_hold, ifid_hold, idex_bubble, ifid_flush} !== 4'b1110) begin
            errors++; $display("FAIL lu_stall got %b exp 1110",
                {pc_hold, ifid_hold, idex_bubble, ifid_flush});
        end
        checks++;
        if (stall_cnt !== 0) begin
            errors++; $display("FAIL lu_cnt_before got %0d exp 0", stall_cnt);
        end
        tick();
        clear_inputs(); #1;
        checks++;
        if ({pc_hold, ifid_hold, idex_bubble} !== 3'b000) begin
            errors++; $display("FAIL lu_one_cycle got %b exp 000", {pc_hold, ifid_hold, idex_bubble});
        end
        checks++;
        if (stall_cnt !== 1) begin
            errors++; $display("FAIL lu_cnt_after got %0d exp 1", stall_cnt);
        end
        tick();
        clear_inputs(); ex_rd = 1; ex_wr = 1; ex_wb = 0; id_u2 = 1; #1;
        checks++;
        if (pc_hold !== 1'b0) begin
            errors++; $display("FAIL lu_x0 got %b exp 0", pc_hold);
        end
        tick();
        clear_inputs(); ex_rd = 1; ex_wr = 1; ex_wb = 7; id_rs2 = 7; id_u2 = 0; #1;
        checks++;
        if (pc_hold !== 1'b0) begin
            errors++; $display("FAIL lu_unused got %b exp 0", pc_hold);
        end
        tick();
        clear_inputs(); ex_rd = 1; ex_wr = 1; ex_wb = 12; id_rs1 = 12; id_u1 = 1; #1;
        checks++;
        if ({pc_hold, idex_bubble} !== 2'b11) begin
            errors++; $display("FAIL lu_rs1 got %b exp 11", {pc_hold, idex_bubble});
        end
        tick();
        clear_inputs(); #1;
        checks++;
        if (stall_cnt !== 2) begin
            errors++; $display("FAIL lu_cnt2 got %0d exp 2", stall_cnt);
        end
        tick();
    endtask

    task automatic test_branch_priority();
        int c0;
        c0 = m_cnt;
        clear_inputs(); br = 1; ex_rd = 1; ex_wr = 1; ex_wb = 7; id_rs2 = 7; id_u2 = 1; #1;
        checks++;
        if ({ifid_flush, idex_bubble, pc_hold, ifid_hold, busy_flush} !== 5'b11000) begin
            errors++; $display("FAIL br_cycle0 got %b exp 11000",
                {ifid_flush, idex_bubble, pc_hold, ifid_hold, busy_flush});
        end
        tick(); #1;
        checks++;
        if ({ifid_flush, idex_bubble, pc_hold, ifid_hold, busy_flush} !== 5'b11001) begin
            errors++; $display("FAIL br_cycle1 got %b exp 11001",
                {ifid_flush, idex_bubble, pc_hold, ifid_hold, busy_flush});
        end
        tick();
        clear_inputs(); #1;
        checks++;
        if ({ifid_flush, idex_bubble, pc_hold, busy_flush} !== 4'b0000) begin
            errors++; $display("FAIL br_done got %b exp 0000",
                {ifid_flush, idex_bubble, pc_hold, busy_flush});
        end
        checks++;
        if (stall_cnt !== CNT_W'(c0)) begin
            errors++; $display("FAIL br_cnt got %0d exp %0d", stall_cnt, c0);
        end
        tick();
    endtask

    task automatic test_reset_in_flush();
        clear_inputs(); br = 1; ex_wr = 1; ex_wb = 3; tick(); #1;
        checks++;
        if (busy_flush !== 1'b1) begin
            errors++; $display("FAIL rif_busy got %b exp 1", busy_flush);
        end
        rstn = 0; model_reset();
        ex_rd = 1; ex_wb = 7; id_rs1 = 7; id_u1 = 1; ex_rs1 = 3; #1;
        checks++;
        if ({pc_hold, ifid_hold, ifid_flush, idex_bubble, busy_flush, fwd_a, fwd_b} !== 9'b0) begin
            errors++; $display("FAIL rif_outputs got %b exp 0",
                {pc_hold, ifid_hold, ifid_flush, idex_bubble, busy_flush, fwd_a, fwd_b});
        end
        checks++;
        if (stall_cnt !== '0) begin
            errors++; $display("FAIL rif_cnt got %0d exp 0", stall_cnt);
        end
        @(posedge clk); #1;
        clear_inputs(); rstn = 1; ex_rs1 = 3; ex_rs2 = 3; #1;
        checks++;
        if ({ifid_flush, idex_bubble, busy_flush, fwd_a, fwd_b} !== 7'b0) begin
            errors++; $display("FAIL rif_release got %b exp 0",
                {ifid_flush, idex_bubble, busy_flush, fwd_a, fwd_b});
        end
        tick(); #1;
        checks++;
        if ({ifid_flush, busy_flush} !== 2'b00) begin
            errors++; $display("FAIL rif_no_flush got %b exp 00", {ifid_flush, busy_flush});
        end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
            ex_rs1 = 5'($urandom_range(0, 3)); ex_rs2 = 5'($urandom_range(0, 3));
            ex_wb  = 5'($urandom_range(0, 3));
            id_u1 = 1'($urandom); id_u2 = 1'($urandom); ex_wr = 1'($urandom);
            ex_rd = ($urandom_range(0, 2) == 0);
            br    = ($urandom_range(0, 7) == 0);
            #1;
            model_eval();
            checks++;
            if ({pc_hold, ifid_hold, ifid_flush, idex_bubble, busy_flush} !==
                {e_pc, e_ifh, e_iff, e_bub, e_busy}) begin
                errors++; $display("FAIL rnd_ctrl cyc %0d got %b exp %b", i,
                    {pc_hold, ifid_hold, ifid_flush, idex_bubble, busy_flush},
                    {e_pc, e_ifh, e_iff, e_bub, e_busy});
            end
            checks++;
            if ({fwd_a, fwd_b} !== {e_fa, e_fb}) begin
                errors++; $display("FAIL rnd_fwd cyc %0d got %b exp %b", i, {fwd_a, fwd_b}, {e_fa, e_fb});
            end
            checks++;
            if (stall_cnt !== CNT_W'(m_cnt)) begin
                errors++; $display("FAIL rnd_cnt cyc %0d got %0d exp %0d", i, stall_cnt, m_cnt);
            end
            checks++;
            if (ifid_hold && ifid_flush) begin
                errors++; $display("FAIL rnd_hold_flush cyc %0d got both 1 exp not both", i);
            end
            tick();
        end
    endtask

    task automatic test_saturation();
        clear_inputs(); rstn = 0; model_reset();
        @(posedge clk); #1;
        rstn = 1;
        ex_rd = 1; ex_wr = 1; ex_wb = 7; id_rs1 = 7; id_u1 = 1;
        repeat (CNT_MAX - 1) @(posedge clk);
        #1;
        checks++;
        if (stall_cnt !== CNT_W'(CNT_MAX - 1)) begin
            errors++; $display("FAIL sat_near got %0d exp %0d", stall_cnt, CNT_MAX - 1);
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (stall_cnt !== {CNT_W{1'b1}}) begin
            errors++; $display("FAIL sat_hold got %0d exp %0d", stall_cnt, CNT_MAX);
        end
        checks++;
        if (pc_hold !== 1'b1) begin
            errors++; $display("FAIL sat_pc_hold got %b exp 1", pc_hold);
        end
        clear_inputs();
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        rstn = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_forward();
        test_load_use();
        test_branch_priority();
        test_reset_in_flush();
        test_random();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have parameter FLUSH_CYCLES, default 2, giving the number of cycles a taken-branch flush lasts (legal range 1..7).
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of the stall performance counter.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rstn  in  1  reset, asynchronous, active-low.
REQ-005 id_rs1_addr, id_rs2_addr  in  5 each  source register addresses of the instruction in ID.
REQ-006 id_rs1_used, id_rs2_used  in  1 each  ID instruction actually reads rs1/rs2.
REQ-007 ex_rs1_addr, ex_rs2_addr  in  5 each  source register addresses from the ID/EX register outputs.
REQ-008 ex_reg_wr, ex_mem_rd  in  1 each  EX instruction writes a register / is a load.
REQ-009 ex_wb_addr  in  5  destination register address of the EX instruction.
REQ-010 branch_taken_ex  in  1  branch/jump in EX resolved taken this cycle.
REQ-011 pc_hold  out  1  freeze PC.
REQ-012 ifid_hold  out  1  freeze IF/ID register.
REQ-013 ifid_flush  out  1  load NOP into IF/ID.
REQ-014 idex_bubble  out  1  zero all ID/EX control fields on next edge.
REQ-015 fwd_a_sel, fwd_b_sel  out  2 each  ALU operand source: 00 register file, 01 MEM/WB, 10 EX/MEM, 11 unused.
REQ-016 stall_cnt  out  CNT_W  count of cycles with pc_hold asserted.
REQ-017 busy_flush  out  1  FSM is in FLUSH state.

Function
REQ-018 The block SHALL hold shadow registers exmem_{reg_wr,mem_rd,wb_addr} loaded from ex_* every cycle, and memwb_{reg_wr,wb_addr} loaded from exmem_* every cycle; these registers SHALL have no enable.
REQ-019 fwd_a_sel SHALL be 10 when exmem_reg_wr=1, exmem_mem_rd=0, exmem_wb_addr!=0 and exmem_wb_addr==ex_rs1_addr; else 01 when memwb_reg_wr=1, memwb_wb_addr!=0 and memwb_wb_addr==ex_rs1_addr; else 00 (combinational, same cycle); fwd_b_sel SHALL follow the same rule using ex_rs2_addr.
REQ-020 Writes to x0 SHALL never produce a forward or a stall.
REQ-021 load_use SHALL be ex_mem_rd & ex_reg_wr & (ex_wb_addr!=0) & ((id_rs1_used & ex_wb_addr==id_rs1_addr) | (id_rs2_used & ex_wb_addr==id_rs2_addr)).
REQ-022 The FSM SHALL have states RUN and FLUSH, with a 3-bit flush counter fcnt.
REQ-023 In RUN with branch_taken_ex=1: ifid_flush=1, idex_bubble=1, pc_hold=0, ifid_hold=0 in that cycle; next state FLUSH with fcnt=FLUSH_CYCLES-1; if FLUSH_CYCLES=1, next state SHALL be RUN.
REQ-024 In RUN with branch_taken_ex=0 and load_use=1: pc_hold=1, ifid_hold=1, idex_bubble=1, ifid_flush=0 (one-cycle stall, Mealy); state SHALL remain RUN.
REQ-025 Branch SHALL take priority over load_use when both occur in the same cycle.
REQ-026 In FLUSH: ifid_flush=1 and idex_bubble=1, pc_hold=0; fcnt SHALL decrement each cycle; the state SHALL return to RUN on the cycle fcnt==0; load_use and branch_taken_ex SHALL be ignored while in FLUSH.
REQ-027 In RUN with no hazard, all of pc_hold, ifid_hold, ifid_flush and idex_bubble SHALL be 0.
REQ-028 stall_cnt SHALL increment by 1 on each edge where pc_hold=1, and SHALL saturate at all-ones without wrapping.
REQ-029 ifid_hold and ifid_flush SHALL never be 1 in the same cycle.

Reset
REQ-030 While rstn=0, the block SHALL set the state to RUN, fcnt=0, all shadow registers to 0 and stall_cnt=0, and SHALL force pc_hold, ifid_hold, ifid_flush, idex_bubble, busy_flush to 0 and fwd_a_sel/fwd_b_sel to 00, regardless of other inputs.
REQ-031 A reset asserted during FLUSH or a stall SHALL abort it immediately; the first cycle after release SHALL behave as RUN with an empty pipeline.

Verification
REQ-032 ex_reg_wr=1, ex_wb_addr=5, next cycle ex_rs1_addr=5 -> fwd_a_sel=10; the cycle after with ex_rs2_addr=5 -> fwd_b_sel=01.
REQ-033 ex_mem_rd=1, ex_reg_wr=1, ex_wb_addr=7, id_rs2_addr=7, id_rs2_used=1 -> pc_hold=ifid_hold=idex_bubble=1 for exactly 1 cycle, stall_cnt 0->1.
REQ-034 Same as REQ-033 with ex_wb_addr=0 or id_rs2_used=0 -> no stall; a write to x0 followed by a read of x0 -> fwd sel 00.
REQ-035 branch_taken_ex and load_use in the same cycle with FLUSH_CYCLES=2 -> ifid_flush=idex_bubble=1 for 2 cycles, pc_hold=0, busy_flush=1 for 1 cycle, stall_cnt unchanged.
REQ-036 Force 2^CNT_W+3 stall cycles -> stall_cnt holds at 0xFFFF (CNT_W=16).
REQ-037 Assert rstn=0 in the 2nd cycle of FLUSH -> all outputs 0 immediately; after release, no flush.
